// File: rtl/fetch_prefetch_queue_pkg.sv
// rtl/fetch_prefetch_queue_pkg.sv - shared fetch constants, queue entry type and PC helper
package fetch_prefetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// rtl/fetch_prefetch_queue_if.sv - memory, redirect and consumer signals of the prefetch queue
interface fetch_prefetch_queue_if
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_npc;
  logic [XLEN-1:0] out_ir;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;

  modport master (
    output imem_req_valid, imem_addr, out_valid, out_pc, out_npc, out_ir, count, outstanding,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_pc, out_npc, out_ir, count, outstanding,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, deq_ready
  );

endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// rtl/fetch_prefetch_queue_sync_fifo.sv - power-of-two synchronous FIFO with flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop only real data; push is allowed when full only if a slot frees in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW + 1)'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: an empty FIFO's head is never consumed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - credit-limited instruction prefetch queue with branch redirect
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   o_cnt;
  logic [CW-1:0]   d_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic [CW:0]     credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_accept;
  logic            out_valid;
  logic            deq_fire;
  logic [XLEN-1:0] tag_head;
  logic [XLEN-1:0] head_pc;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push;

  // Queued entries plus in-flight requests may never exceed DEPTH, so every
  // accepted response is guaranteed a free queue slot.
  assign credit_used = {1'b0, q_count} + {1'b0, o_cnt};
  assign req_valid   = !rst && !bus.redirect_valid && (credit_used < (CW + 1)'(DEPTH));
  assign req_fire    = req_valid && bus.imem_req_ready;

  // A response with nothing outstanding (e.g. left over from before reset) is ignored.
  assign rsp_live   = bus.imem_rsp_valid && (o_cnt != '0);
  assign rsp_accept = rsp_live && !bus.redirect_valid && (d_cnt == '0);
  assign out_valid  = (q_count != '0);
  assign deq_fire   = out_valid && bus.deq_ready && !bus.redirect_valid;
  assign q_push     = '{pc: tag_head, ir: bus.imem_rsp_data};

  assign head_pc             = out_valid ? q_head.pc : '0;
  assign bus.imem_req_valid  = req_valid;
  assign bus.imem_addr       = fetch_pc;
  assign bus.out_valid       = out_valid;
  assign bus.out_pc          = head_pc;
  assign bus.out_npc         = next_pc(head_pc);
  assign bus.out_ir          = out_valid ? q_head.ir : NOP_INST;
  assign bus.count           = q_count;
  assign bus.outstanding     = o_cnt;

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_inst_q (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_accept),
    .push_data(q_push),
    .pop      (deq_fire),
    .flush    (bus.redirect_valid),
    .head_data(q_head),
    .count    (q_count)
  );

  // Addresses of requests whose responses will still be kept; dropped ones
  // were cleared together with the redirect that orphaned them.
  sync_fifo #(
    .WIDTH(XLEN),
    .DEPTH(DEPTH)
  ) u_tag_q (
    .clk      (clk),
    .rst      (rst),
    .push     (req_fire),
    .push_data(fetch_pc),
    .pop      (rsp_accept),
    .flush    (bus.redirect_valid),
    .head_data(tag_head),
    .count    (tag_count)
  );

  // Fetch PC, in-flight count and drop counter; a redirect marks every
  // response still in flight after this cycle for discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      o_cnt    <= '0;
      d_cnt    <= '0;
    end else begin
      o_cnt <= o_cnt + CW'(req_fire) - CW'(rsp_live);
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
        d_cnt    <= o_cnt - CW'(rsp_live);
      end else begin
        if (req_fire) fetch_pc <= next_pc(fetch_pc);
        if (rsp_live && (d_cnt != '0)) d_cnt <= d_cnt - 1'b1;
      end
    end
  end

  a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (o_cnt != '0));
  a_rsp_has_room: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (q_count != CW'(DEPTH)));
  a_tags_cover_kept: assert property (@(posedge clk) disable iff (rst)
    tag_count <= o_cnt);

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - randomized prefetch queue bench against a queue-level reference model
module tb_fetch_prefetch_queue;
  import fetch_prefetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct { logic [31:0] pc; bit drop; } flight_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] m_q_pc[$];
  logic [31:0] m_q_ir[$];
  flight_t     m_fl[$];
  logic [31:0] m_fetch_pc;
  pend_t       mem_q[$];
  logic [31:0] deq_log[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_due = 0;
  int reqs_issued = 0;
  int lat_min = 1, lat_max = 1, ready_pct = 100, deq_pct = 100, redir_pct = 0;

  logic        s_out_valid, s_req_valid;
  logic [31:0] s_out_pc, s_out_ir, s_addr;
  logic [CW-1:0] s_count, s_outstanding;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ a[15:0]};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < deq_log.size()) return deq_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_outputs(input bit redir);
    bit ev;
    logic [31:0] epc;
    logic [31:0] eir;
    ev  = (m_q_pc.size() > 0);
    epc = ev ? m_q_pc[0] : 32'h0;
    eir = ev ? m_q_ir[0] : NOP_INST;
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("out_pc", bus.out_pc, epc);
    chk("out_npc", bus.out_npc, epc + 32'd4);
    chk("out_ir", bus.out_ir, eir);
    chk("count", 32'(bus.count), m_q_pc.size());
    chk("outstanding", 32'(bus.outstanding), m_fl.size());
    chk("req_valid", 32'(bus.imem_req_valid), 32'(!redir && (m_q_pc.size() + m_fl.size() < DEPTH)));
    chk("imem_addr", bus.imem_addr, m_fetch_pc);
    chk("credit_bound", 32'((32'(bus.count) + 32'(bus.outstanding)) <= DEPTH), 32'd1);
  endtask

  task automatic step(input bit redir, input logic [31:0] tgt);
    bit rsp, deq, m_req;
    logic [31:0] raddr;
    flight_t f;
    int d_at;
    @(negedge clk);
    rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.deq_ready      = ($urandom_range(99) < deq_pct);
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.imem_rsp_valid = rsp;
    if (rsp) begin
      raddr = mem_q[0].addr;
      void'(mem_q.pop_front());
      bus.imem_rsp_data = img(raddr);
    end else begin
      bus.imem_rsp_data = $urandom;
    end
    #1;
    compare_outputs(redir);
    s_out_valid = bus.out_valid;  s_out_pc = bus.out_pc;  s_out_ir = bus.out_ir;
    s_count = bus.count;  s_outstanding = bus.outstanding;
    s_req_valid = bus.imem_req_valid;  s_addr = bus.imem_addr;
    // memory side: accept the handshake the DUT actually offers
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      d_at = cyc + int'($urandom_range(lat_max, lat_min));
      if (d_at <= last_due) d_at = last_due + 1;
      last_due = d_at;
      mem_q.push_back('{addr: bus.imem_addr, due: d_at});
      reqs_issued++;
    end
    // reference model: queue of entries, list of in-flight requests with drop marks
    m_req = !redir && (m_q_pc.size() + m_fl.size() < DEPTH);
    deq   = bus.deq_ready && (m_q_pc.size() > 0);
    if (redir) begin
      if (rsp && m_fl.size() > 0) void'(m_fl.pop_front());
      foreach (m_fl[i]) m_fl[i].drop = 1'b1;
      m_q_pc.delete();
      m_q_ir.delete();
      m_fetch_pc = tgt;
    end else begin
      if (deq) begin
        deq_log.push_back(m_q_pc[0]);
        void'(m_q_pc.pop_front());
        void'(m_q_ir.pop_front());
      end
      if (rsp && m_fl.size() > 0) begin
        f = m_fl.pop_front();
        if (!f.drop) begin
          m_q_pc.push_back(f.pc);
          m_q_ir.push_back(img(f.pc));
        end
      end
      if (m_req && bus.imem_req_ready) begin
        m_fl.push_back('{pc: m_fetch_pc, drop: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.deq_ready      = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_npc", bus.out_npc, 32'h4);
    chk("rst_out_ir", bus.out_ir, 32'h0000_0013);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    m_q_pc.delete();  m_q_ir.delete();  m_fl.delete();
    mem_q.delete();  deq_log.delete();
    m_fetch_pc = RESET_PC;
    last_due = cyc;
    reqs_issued = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    int o_before;
    logic [31:0] tgt;

    // latency 1, always dequeue: sequential PC stream
    lat_min = 1; lat_max = 1; ready_pct = 100; deq_pct = 100; redir_pct = 0;
    do_reset();
    step(0, 0);
    chk("s1_first_req", 32'(s_req_valid), 32'd1);
    chk("s1_first_addr", s_addr, 32'h0);
    step(0, 0);
    step(0, 0);
    chk("s1_head_pc", s_out_pc, 32'h0);
    chk("s1_head_ir", s_out_ir, 32'hC0DE_0000);
    repeat (9) step(0, 0);
    chk("s1_log0", log_at(0), 32'h0);
    chk("s1_log1", log_at(1), 32'h4);
    chk("s1_log2", log_at(2), 32'h8);
    chk("s1_log3", log_at(3), 32'hC);

    // no dequeue, latency 2: exactly DEPTH requests then stall
    lat_min = 2; lat_max = 2; deq_pct = 0;
    do_reset();
    repeat (10) step(0, 0);
    chk("s2_count_full", 32'(s_count), 32'd4);
    chk("s2_outstanding", 32'(s_outstanding), 32'd0);
    chk("s2_req_blocked", 32'(s_req_valid), 32'd0);
    chk("s2_reqs_issued", reqs_issued, 32'd4);
    deq_pct = 100;
    step(0, 0);
    deq_pct = 0;
    step(0, 0);
    chk("s2_count_after_deq", 32'(s_count), 32'd3);
    chk("s2_req_resumes", 32'(s_req_valid), 32'd1);

    // latency 3, three in flight, redirect to 0x100
    lat_min = 3; lat_max = 3; deq_pct = 100;
    do_reset();
    repeat (3) step(0, 0);
    step(1, 32'h100);
    chk("s3_inflight", 32'(s_outstanding), 32'd3);
    step(0, 0);
    chk("s3_target_req", 32'(s_req_valid), 32'd1);
    chk("s3_target_addr", s_addr, 32'h100);
    n = 1;
    while (!s_out_valid && n < 20) begin
      step(0, 0);
      n++;
    end
    chk("s3_redirect_latency", n, 32'd5);
    chk("s3_head_pc", s_out_pc, 32'h100);
    chk("s3_head_ir", s_out_ir, 32'hC1DE_0100);
    repeat (4) step(0, 0);
    chk("s3_log0", log_at(0), 32'h100);
    chk("s3_log1", log_at(1), 32'h104);

    // redirect coinciding with a response and a dequeue
    lat_min = 2; lat_max = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due == cyc && m_q_pc.size() > 0) found = 1;
      else step(0, 0);
    end
    chk("s4_found_slot", 32'(found), 32'd1);
    o_before = m_fl.size();
    deq_log.delete();
    step(1, 32'h200);
    step(0, 0);
    chk("s4_count_cleared", 32'(s_count), 32'd0);
    chk("s4_outstanding", 32'(s_outstanding), 32'(o_before - 1));
    n = 0;
    while (!s_out_valid && n < 20) begin
      step(0, 0);
      n++;
    end
    chk("s4_head_pc", s_out_pc, 32'h200);
    chk("s4_head_ir", s_out_ir, img(32'h200));

    // reset with two queued and two in flight
    lat_min = 4; lat_max = 4; deq_pct = 0;
    do_reset();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(0, 0);
      if (m_q_pc.size() == 2 && m_fl.size() == 2) found = 1;
    end
    chk("s5_found_state", 32'(found), 32'd1);
    do_reset();
    step(0, 0);
    chk("s5_restart_req", 32'(s_req_valid), 32'd1);
    chk("s5_restart_addr", s_addr, RESET_PC);

    // random latency, backpressure, dequeue and redirects
    lat_min = 1; lat_max = 5; ready_pct = 70; deq_pct = 60; redir_pct = 5;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < redir_pct) begin
        tgt = 32'($urandom_range(255)) << 2;
        if ($urandom_range(9) == 0) tgt = 32'hFFFF_FFF0;
        step(1, tgt);
      end else begin
        step(0, 0);
      end
      if (i == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
